// File: rtl/ninjakun_shbus_arbiter_if.sv
// ---------------------------------------------------------------------------
// ninjakun_shbus_arbiter_if
//   One requester channel of the shared IO/video bus arbiter.
//   Each requester holds REQ with AD/OD/WR stable until ACK pulses. Read
//   data for that requester is returned on ID.
//   Signals:
//     REQ  requester -> arbiter  request, level
//     AD   requester -> arbiter  16-bit address
//     OD   requester -> arbiter  8-bit write data
//     WR   requester -> arbiter  1 = write, 0 = read
//     ID   arbiter -> requester  8-bit read data, registered
//     ACK  arbiter -> requester  completion pulse, one cycle
//   Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface ninjakun_shbus_arbiter_if;
  logic        REQ;
  logic [15:0] AD;
  logic [7:0]  OD;
  logic        WR;
  logic [7:0]  ID;
  logic        ACK;

  modport master (output REQ, AD, OD, WR, input ID, ACK);
  modport slave  (input REQ, AD, OD, WR, output ID, ACK);
endinterface

// File: rtl/ninjakun_shbus_arbiter.sv
// ---------------------------------------------------------------------------
// ninjakun_shbus_arbiter
//   Request/acknowledge arbiter for the shared IO/video bus (PSG, FG/BG VRAM,
//   sprite RAM, palette). Three requesters (CPU0, CPU1, hiscore port) compete
//   for single fixed-length bus cycles; idle requesters consume no slots.
//   Parameters:
//     LAT        cycles the bus strobes stay high per access (1..7)
//     HS_MAXRUN  consecutive hiscore grants allowed while a CPU waits (1..15)
//   Ports:
//     SHCLK    bus clock, all state on rising edge
//     RESET_N  asynchronous active-low reset
//     c0/c1/hs requester channels (REQ/AD/OD/WR in, ID/ACK out)
//     CPADR    shared bus address        CPODT  shared bus write data
//     CPRED    shared bus read strobe    CPWRT  shared bus write strobe
//     CPIDT    shared bus read data, valid while CPRED is high
//     BUSY     high whenever the arbiter is not idle
//   Sequence: IDLE (arbitrate) -> ACCESS (strobes for LAT cycles)
//             -> DONE (ACK pulse) -> IDLE. Every output is a register.
// ---------------------------------------------------------------------------
module ninjakun_shbus_arbiter #(
  parameter int LAT       = 2,
  parameter int HS_MAXRUN = 4
) (
  input  logic                           SHCLK,
  input  logic                           RESET_N,
  ninjakun_shbus_arbiter_if.slave        c0,
  ninjakun_shbus_arbiter_if.slave        c1,
  ninjakun_shbus_arbiter_if.slave        hs,
  output logic [15:0]                    CPADR,
  output logic [7:0]                     CPODT,
  output logic                           CPRED,
  output logic                           CPWRT,
  input  logic [7:0]                     CPIDT,
  output logic                           BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  typedef enum logic [1:0] {SEL_C0, SEL_C1, SEL_HS} sel_t;

  localparam logic [2:0] CNT_INIT = 3'(LAT - 1);
  localparam logic [3:0] HS_LIMIT = 4'(HS_MAXRUN);

  state_t      state;
  sel_t        sel;
  sel_t        win;
  logic        last_c1;   // 1 when CPU1 took the most recent CPU grant
  logic [2:0]  cnt;
  logic [3:0]  hsrun;     // hiscore grants since the last CPU grant
  logic        any_req;
  logic [15:0] win_ad;
  logic [7:0]  win_od;
  logic        win_wr;

  // Winner selection. Hiscore has priority until it has run HS_MAXRUN
  // times in a row while a CPU is waiting; contending CPUs alternate.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    any_req = c0.REQ | c1.REQ | hs.REQ;
    win     = SEL_C0;
    if (hs.REQ && ((hsrun < HS_LIMIT) || !(c0.REQ | c1.REQ)))
      win = SEL_HS;
    else if (c0.REQ && c1.REQ)
      win = last_c1 ? SEL_C0 : SEL_C1;
    else if (c1.REQ)
      win = SEL_C1;
  end

  always_comb begin
    win_ad = c0.AD;
    win_od = c0.OD;
    win_wr = c0.WR;
    case (win)
      SEL_C1: begin
        win_ad = c1.AD;
        win_od = c1.OD;
        win_wr = c1.WR;
      end
      SEL_HS: begin
        win_ad = hs.AD;
        win_od = hs.OD;
        win_wr = hs.WR;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the design holds no memories, so every register (including the
  // read-data holders) has a defined reset value.
  always_ff @(posedge SHCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= S_IDLE;
      sel     <= SEL_C0;
      last_c1 <= 1'b1;    // so CPU0 wins the first CPU tie
      cnt     <= '0;
      hsrun   <= '0;
      CPADR   <= '0;
      CPODT   <= '0;
      CPRED   <= 1'b0;
      CPWRT   <= 1'b0;
      BUSY    <= 1'b0;
      c0.ID   <= '0;
      c1.ID   <= '0;
      hs.ID   <= '0;
      c0.ACK  <= 1'b0;
      c1.ACK  <= 1'b0;
      hs.ACK  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            sel   <= win;
            CPADR <= win_ad;
            CPODT <= win_od;
            CPWRT <= win_wr;
            CPRED <= ~win_wr;
            cnt   <= CNT_INIT;
            BUSY  <= 1'b1;
            state <= S_ACCESS;
            if (win == SEL_HS) begin
              if (hsrun != 4'hF) hsrun <= hsrun + 4'd1;
            end else begin
              last_c1 <= (win == SEL_C1);
              hsrun   <= '0;
            end
          end
        end

        S_ACCESS: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            // Last strobe cycle: read data is still valid on CPIDT here.
            case (sel)
              SEL_C0: begin
                if (CPRED) c0.ID <= CPIDT;
                c0.ACK <= 1'b1;
              end
              SEL_C1: begin
                if (CPRED) c1.ID <= CPIDT;
                c1.ACK <= 1'b1;
              end
              default: begin
                if (CPRED) hs.ID <= CPIDT;
                hs.ACK <= 1'b1;
              end
            endcase
            CPRED <= 1'b0;
            CPWRT <= 1'b0;
            CPADR <= '0;
            CPODT <= '0;
            state <= S_DONE;
          end
        end

        S_DONE: begin
          // No arbitration here: a requester still holding REQ from the
          // access just acknowledged cannot be granted a second time.
          c0.ACK <= 1'b0;
          c1.ACK <= 1'b0;
          hs.ACK <= 1'b0;
          BUSY   <= 1'b0;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ninjakun_shbus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ninjakun_shbus_arbiter
//   Randomized requesters push expected transactions into per-requester
//   queues; a negedge monitor predicts each grant from the arbitration rules,
//   and on every ACK pops and compares bus address/data/direction, strobe
//   length, winner identity and returned read data.
// ---------------------------------------------------------------------------
module tb_ninjakun_shbus_arbiter;
  localparam int LAT        = 2;
  localparam int HS_MAXRUN  = 4;
  localparam int WAIT_BOUND = 400;

  typedef struct packed {
    logic [15:0] ad;
    logic [7:0]  od;
    logic        wr;
  } txn_t;

  logic SHCLK   = 1'b0;
  logic RESET_N = 1'b1;
  always #5 SHCLK = ~SHCLK;

  ninjakun_shbus_arbiter_if c0_if ();
  ninjakun_shbus_arbiter_if c1_if ();
  ninjakun_shbus_arbiter_if hs_if ();

  logic [15:0] CPADR;
  logic [7:0]  CPODT;
  logic [7:0]  CPIDT;
  logic        CPRED;
  logic        CPWRT;
  logic        BUSY;

  logic [2:0]  req = '0;
  logic [2:0]  wr  = '0;
  logic [15:0] ad [3];
  logic [7:0]  od [3];
  logic [7:0]  id [3];
  logic [2:0]  ack;

  assign c0_if.REQ = req[0];
  assign c1_if.REQ = req[1];
  assign hs_if.REQ = req[2];
  assign c0_if.WR  = wr[0];
  assign c1_if.WR  = wr[1];
  assign hs_if.WR  = wr[2];
  assign c0_if.AD  = ad[0];
  assign c1_if.AD  = ad[1];
  assign hs_if.AD  = ad[2];
  assign c0_if.OD  = od[0];
  assign c1_if.OD  = od[1];
  assign hs_if.OD  = od[2];
  assign id[0]     = c0_if.ID;
  assign id[1]     = c1_if.ID;
  assign id[2]     = hs_if.ID;
  assign ack       = {hs_if.ACK, c1_if.ACK, c0_if.ACK};

  function automatic logic [7:0] rd_fn(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  // Bus slave: data only while the read strobe is up.
  assign CPIDT = CPRED ? rd_fn(CPADR) : 8'h00;

  ninjakun_shbus_arbiter #(.LAT(LAT), .HS_MAXRUN(HS_MAXRUN)) dut (
    .SHCLK   (SHCLK),
    .RESET_N (RESET_N),
    .c0      (c0_if),
    .c1      (c1_if),
    .hs      (hs_if),
    .CPADR   (CPADR),
    .CPODT   (CPODT),
    .CPRED   (CPRED),
    .CPWRT   (CPWRT),
    .CPIDT   (CPIDT),
    .BUSY    (BUSY)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard and reference model state.
  txn_t       exp_q0[$];
  txn_t       exp_q1[$];
  txn_t       exp_q2[$];
  int         grant_q[$];
  int         model_hs_streak = 0;
  bit         model_last_c1   = 1'b1;
  logic [7:0] model_id [3]    = '{8'h00, 8'h00, 8'h00};

  task automatic push_exp(input int r, input txn_t t);
    case (r)
      0:       exp_q0.push_back(t);
      1:       exp_q1.push_back(t);
      default: exp_q2.push_back(t);
    endcase
  endtask

  task automatic pop_exp(input int r, output txn_t t, output bit ok);
    ok = 1'b1;
    t  = '0;
    case (r)
      0:       if (exp_q0.size() > 0) t = exp_q0.pop_front(); else ok = 1'b0;
      1:       if (exp_q1.size() > 0) t = exp_q1.pop_front(); else ok = 1'b0;
      default: if (exp_q2.size() > 0) t = exp_q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    grant_q.delete();
    model_hs_streak = 0;
    model_last_c1   = 1'b1;
    for (int i = 0; i < 3; i++) model_id[i] = 8'h00;
  endtask

  // Monitor.
  bit          mon_en      = 1'b0;
  bit          prev_strobe = 1'b0;
  bit          prev_busy   = 1'b0;
  logic [2:0]  prev_req    = '0;
  int          run         = 0;
  logic [15:0] bus_ad;
  logic [7:0]  bus_od;
  logic        bus_wr;

  always @(negedge SHCLK) begin : monitor
    logic strobe;
    int   who;
    int   exp_who;
    txn_t t;
    bit   ok;
    if (!RESET_N || !mon_en) begin
      prev_strobe = 1'b0;
      prev_busy   = 1'b0;
      run         = 0;
    end else begin
      strobe = CPRED | CPWRT;
      check("busy", BUSY, strobe || (ack != 3'b000));
      check("ack_onehot", ($countones(ack) <= 1), 1);
      if (!strobe) begin
        check("idle_cpadr", CPADR, 0);
        check("idle_cpodt", CPODT, 0);
      end else begin
        check("rd_xor_wr", CPRED ^ CPWRT, 1);
      end
      if (!prev_busy && prev_req != 3'b000) check("grant_taken", strobe, 1);

      if (strobe && !prev_strobe) begin
        check("no_grant_in_done", prev_busy, 0);
        // Reference arbitration from the REQ levels seen at the grant edge.
        if (prev_req[2] && (!(prev_req[0] || prev_req[1]) || model_hs_streak < HS_MAXRUN)) begin
          exp_who = 2;
          if (model_hs_streak < 15) model_hs_streak++;
        end else begin
          if (prev_req[0] && prev_req[1]) exp_who = model_last_c1 ? 0 : 1;
          else                           exp_who = prev_req[1] ? 1 : 0;
          model_last_c1   = (exp_who == 1);
          model_hs_streak = 0;
        end
        grant_q.push_back(exp_who);
        bus_ad = CPADR;
        bus_od = CPODT;
        bus_wr = CPWRT;
        run    = 1;
      end else if (strobe) begin
        run++;
        check("cpadr_hold", CPADR, bus_ad);
        check("cpwrt_hold", CPWRT, bus_wr);
      end

      if (ack != 3'b000) begin
        who = ack[2] ? 2 : (ack[1] ? 1 : 0);
        check("ack_after_strobe", prev_strobe, 1);
        check("strobe_len", run, LAT);
        check("ack_no_strobe", strobe, 0);
        if (grant_q.size() == 0) check("grant_pending", 0, 1);
        else                     check("grant_winner", who, grant_q.pop_front());
        pop_exp(who, t, ok);
        if (!ok) begin
          check("exp_pending", 0, 1);
        end else begin
          check("bus_adr", bus_ad, t.ad);
          check("bus_wr", bus_wr, t.wr);
          if (t.wr) check("bus_odt", bus_od, t.od);
          else      model_id[who] = rd_fn(t.ad);
          for (int i = 0; i < 3; i++) check("id_value", id[i], model_id[i]);
        end
      end
      if (!strobe) run = 0;
      prev_strobe = strobe;
      prev_busy   = strobe || (ack != 3'b000);
    end
    prev_req = req;
  end

  // Requester: n accesses, random idle gap of 0..gap_max cycles between them.
  // With gap 0, REQ stays high through ACK and the next payload follows.
  task automatic run_requester(input int r, input int n, input int gap_max);
    txn_t t;
    int   gap;
    int   waited;
    bit   got;
    for (int k = 0; k < n; k++) begin
      gap = (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0));
      if (gap > 0) begin
        req[r] = 1'b0;
        repeat (gap) @(posedge SHCLK);
        #1;
      end
      t.ad  = 16'($urandom);
      t.od  = 8'($urandom);
      t.wr  = 1'($urandom);
      ad[r] = t.ad;
      od[r] = t.od;
      wr[r] = t.wr;
      req[r] = 1'b1;
      push_exp(r, t);
      waited = 0;
      got    = 1'b0;
      while (!got && waited < WAIT_BOUND) begin
        @(negedge SHCLK);
        waited++;
        if (ack[r]) got = 1'b1;
      end
      check("ack_timeout", got, 1);
      @(posedge SHCLK);
      #1;
    end
    req[r] = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int waited;
    for (int i = 0; i < 3; i++) begin
      ad[i] = '0;
      od[i] = '0;
    end

    // Reset state.
    #3 RESET_N = 1'b0;
    #1;
    check("rst_cpadr", CPADR, 0);
    check("rst_cpodt", CPODT, 0);
    check("rst_cpred", CPRED, 0);
    check("rst_cpwrt", CPWRT, 0);
    check("rst_busy", BUSY, 0);
    check("rst_ack", ack, 0);
    for (int i = 0; i < 3; i++) check("rst_id", id[i], 0);
    repeat (2) @(negedge SHCLK);
    #2 RESET_N = 1'b1;
    mon_en = 1'b1;

    // CPU0 read, then reset while its strobe is up.
    @(posedge SHCLK);
    #1;
    ad[0] = 16'hA000;
    wr[0] = 1'b0;
    req[0] = 1'b1;
    push_exp(0, '{ad: 16'hA000, od: 8'h00, wr: 1'b0});
    waited = 0;
    while (!CPRED && waited < 20) begin
      @(negedge SHCLK);
      waited++;
    end
    check("first_read_strobe", CPRED, 1);
    check("first_read_adr", CPADR, 16'hA000);
    #2 RESET_N = 1'b0;
    #1;
    check("async_rst_cpred", CPRED, 0);
    check("async_rst_cpwrt", CPWRT, 0);
    check("async_rst_busy", BUSY, 0);
    check("async_rst_ack", ack, 0);
    req = '0;
    model_reset();

    // Both CPUs waiting across reset release: CPU0 first, then alternate.
    fork
      run_requester(0, 3, 0);
      run_requester(1, 3, 0);
      begin
        @(negedge SHCLK);
        #2 RESET_N = 1'b1;
      end
    join

    // CPUs back-to-back.
    fork
      run_requester(0, 8, 0);
      run_requester(1, 8, 0);
    join

    // All three back-to-back: hiscore runs capped while CPUs wait.
    fork
      run_requester(0, 6, 0);
      run_requester(1, 6, 0);
      run_requester(2, 14, 0);
    join

    // Hiscore alone, back-to-back.
    run_requester(2, 5, 0);

    // Random traffic with idle gaps.
    fork
      run_requester(0, 25, 3);
      run_requester(1, 25, 3);
      run_requester(2, 25, 3);
    join

    repeat (6) @(negedge SHCLK);
    check("drained", exp_q0.size() + exp_q1.size() + exp_q2.size() + grant_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
